logic_reduce_unit: RTL and testbench

LOGIC_REDUCE_UNIT -- requirements
Module: logic_reduce_unit

---
 rtl/logic_reduce_pkg.sv | 22 ++
 rtl/logic_reduce_unit_reduce_core.sv | 55 +++++
 rtl/logic_reduce_unit.sv | 122 ++++++++++++
 tb/tb_logic_reduce_unit.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/logic_reduce_pkg.sv
// Shared types for the logic reduce unit: operation select encoding and
// output FIFO occupancy states.
package logic_reduce_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_MAJ  = 3'd6,
    OP_RSVD = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    FIFO_EMPTY = 2'd0,
    FIFO_ONE   = 2'd1,
    FIFO_TWO   = 2'd2
  } fifo_state_e;

endpackage

// File: rtl/logic_reduce_unit_reduce_core.sv
// Combinational masked reduction of WIDTH operand bits; masked-off bits act
// as the identity of the selected operation and are not counted for MAJ.
module reduce_core
  import logic_reduce_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] in_mask,
  input  logic [2:0]       in_op,
  output logic             f
);

  // One spare bit so that twice the set-bit count never overflows.
  localparam int CW = $clog2(WIDTH + 1) + 1;

  logic [WIDTH-1:0] act_s;
  logic             all_s;
  logic             any_s;
  logic             par_s;
  logic             maj_s;
  logic [CW-1:0]    ones_s;
  logic [CW-1:0]    mcnt_s;

  // Partial reductions shared by the true and inverted operations
  always_comb begin
    act_s  = in_data & in_mask;
    all_s  = &(in_data | ~in_mask);
    any_s  = |act_s;
    par_s  = ^act_s;
    ones_s = '0;
    mcnt_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones_s = ones_s + CW'(act_s[i]);
      mcnt_s = mcnt_s + CW'(in_mask[i]);
    end
    maj_s = {ones_s[CW-2:0], 1'b0} > mcnt_s;
  end

  // Operation select
  always_comb begin
    case (op_e'(in_op))
      OP_AND:  f = all_s;
      OP_OR:   f = any_s;
      OP_XOR:  f = par_s;
      OP_NAND: f = ~all_s;
      OP_NOR:  f = ~any_s;
      OP_XNOR: f = ~par_s;
      OP_MAJ:  f = maj_s;
      OP_RSVD: f = 1'b0;
      default: f = 1'b0;
    endcase
  end

endmodule

// File: rtl/logic_reduce_unit.sv
// Logic reduce unit: valid/ready front end, 2-entry result FIFO and a
// saturating count of popped results equal to 1.
module logic_reduce_unit
  import logic_reduce_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] in_mask,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_f,
  output logic [CNT_W-1:0] true_cnt
);

  fifo_state_e      state_r;
  fifo_state_e      state_nxt;
  logic             head_r;
  logic             tail_r;
  logic [CNT_W-1:0] cnt_r;
  logic             f_s;
  logic             push_s;
  logic             pop_s;

  reduce_core #(.WIDTH(WIDTH)) u_core (
    .in_data (in_data),
    .in_mask (in_mask),
    .in_op   (in_op),
    .f       (f_s)
  );

  // Occupancy state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= FIFO_EMPTY;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next occupancy from push/pop
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      FIFO_EMPTY: state_nxt = push_s ? FIFO_ONE : FIFO_EMPTY;
      FIFO_ONE: begin
        if (push_s && !pop_s) begin
          state_nxt = FIFO_TWO;
        end else if (pop_s && !push_s) begin
          state_nxt = FIFO_EMPTY;
        end else begin
          state_nxt = FIFO_ONE;
        end
      end
      FIFO_TWO:   state_nxt = (pop_s && !push_s) ? FIFO_ONE : FIFO_TWO;
      default:    state_nxt = FIFO_EMPTY;
    endcase
  end

  // Handshake outputs; everything is held quiet while reset is applied
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    if (rst) begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
    end else begin
      out_valid = (state_r != FIFO_EMPTY);
      in_ready  = (state_r != FIFO_TWO) || out_ready;
    end
  end

  assign push_s   = in_valid & in_ready;
  assign pop_s    = out_valid & out_ready;
  assign out_f    = out_valid & head_r;
  assign true_cnt = rst ? '0 : cnt_r;

  // FIFO storage: head is the presented result, tail the one queued behind it
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r <= 1'b0;
      tail_r <= 1'b0;
    end else begin
      case (state_r)
        FIFO_EMPTY: if (push_s) head_r <= f_s;
        FIFO_ONE: begin
          if (push_s && pop_s) begin
            head_r <= f_s;
          end else if (push_s) begin
            tail_r <= f_s;
          end
        end
        FIFO_TWO: begin
          if (pop_s) begin
            head_r <= tail_r;
            if (push_s) tail_r <= f_s;
          end
        end
        default: begin
          head_r <= 1'b0;
          tail_r <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of popped true results
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (pop_s && head_r && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_logic_reduce_unit.sv
// Scoreboard bench for logic_reduce_unit: directed scenarios plus random
// traffic, expected results from a bit-counting reference model.
module tb_logic_reduce_unit;

  localparam int W  = 32;
  localparam int CW = 4;
  localparam int CNT_MAX = 15;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [W-1:0]  in_mask;
  logic [2:0]    in_op;
  logic          out_valid;
  logic          out_ready;
  logic          out_f;
  logic [CW-1:0] true_cnt;

  int checks = 0;
  int passes = 0;
  bit sb[$];
  int exp_cnt = 0;

  logic_reduce_unit #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mask   (in_mask),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_f     (out_f),
    .true_cnt  (true_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: decide from counts of participating bits
  function automatic bit ref_f(input logic [2:0] op, input logic [W-1:0] d, input logic [W-1:0] m);
    int n;
    int ones;
    bit all_one;
    n = $countones(m);
    ones = $countones(d & m);
    all_one = (ones == n);
    case (op)
      3'd0: return all_one;
      3'd1: return ones > 0;
      3'd2: return (ones % 2) == 1;
      3'd3: return !all_one;
      3'd4: return ones == 0;
      3'd5: return (ones % 2) == 0;
      3'd6: return 2 * ones > n;
      default: return 1'b0;
    endcase
  endfunction

  // One cycle of stimulus; the expected result enters the scoreboard at the accepting edge
  task automatic drive(input bit v, input logic [2:0] op, input logic [W-1:0] d,
                       input logic [W-1:0] m, input bit ordy);
    bit e;
    in_valid  = v;
    in_op     = op;
    in_data   = d;
    in_mask   = m;
    out_ready = ordy;
    e = ref_f(op, d, m);
    #8;
    if (rst) begin
      sb.delete();
      exp_cnt = 0;
    end else if (in_valid && in_ready) begin
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares DUT outputs against the scoreboard and the count model
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_f", 32'(out_f), 32'd0);
      chk("rst_true_cnt", 32'(true_cnt), 32'd0);
    end else begin
      chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
      chk("in_ready", 32'(in_ready), 32'((sb.size() < 2) || out_ready));
      chk("true_cnt", 32'(true_cnt), 32'(exp_cnt));
      if (out_valid && sb.size() != 0) begin
        chk("out_f", 32'(out_f), 32'(sb[0]));
        if (out_ready) begin
          if (sb[0] && exp_cnt < CNT_MAX) exp_cnt++;
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_mask = '0;
    in_op = 3'd0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    drive(1'b0, 3'd0, '0, '0, 1'b1);
    drive(1'b0, 3'd0, '0, '0, 1'b1);
    rst = 1'b0;

    // AND over full mask: 1 then 0
    drive(1'b1, 3'd0, 32'h0000_000F, 32'h0000_000F, 1'b1);
    drive(1'b1, 3'd0, 32'h0000_000E, 32'h0000_000F, 1'b1);
    drive(1'b0, 3'd0, '0, '0, 1'b1);
    chk("and_true_cnt", 32'(true_cnt), 32'd1);

    // MAJ majority, tie, empty mask; NOR empty mask
    drive(1'b1, 3'd6, 32'h0000_0007, 32'h0000_000F, 1'b1);
    drive(1'b1, 3'd6, 32'h0000_0003, 32'h0000_000F, 1'b1);
    drive(1'b1, 3'd6, 32'h0000_000F, 32'h0000_0000, 1'b1);
    drive(1'b1, 3'd4, 32'h0000_000F, 32'h0000_0000, 1'b1);
    // Wide XOR over upper half only
    drive(1'b1, 3'd2, 32'h0001_0001, 32'hFFFF_0000, 1'b1);
    drive(1'b0, 3'd0, '0, '0, 1'b1);

    // Backpressure: third request blocked until the first pop
    drive(1'b1, 3'd1, 32'h0000_0001, 32'h0000_0001, 1'b0);
    drive(1'b1, 3'd0, 32'h0000_0001, 32'h0000_0003, 1'b0);
    drive(1'b1, 3'd5, 32'h0000_0003, 32'h0000_0003, 1'b0);
    drive(1'b1, 3'd5, 32'h0000_0003, 32'h0000_0003, 1'b0);
    drive(1'b1, 3'd5, 32'h0000_0003, 32'h0000_0003, 1'b1);
    drive(1'b0, 3'd0, '0, '0, 1'b1);
    drive(1'b0, 3'd0, '0, '0, 1'b1);

    // Reset with the FIFO full discards results
    drive(1'b1, 3'd1, 32'h0000_0001, 32'h0000_0001, 1'b0);
    drive(1'b1, 3'd1, 32'h0000_0001, 32'h0000_0001, 1'b0);
    rst = 1'b1;
    drive(1'b0, 3'd0, '0, '0, 1'b1);
    rst = 1'b0;
    drive(1'b0, 3'd0, '0, '0, 1'b1);

    // Saturation: 20 true results at full rate
    for (int i = 0; i < 20; i++) drive(1'b1, 3'd0, W'($urandom), '0, 1'b1);
    drive(1'b0, 3'd0, '0, '0, 1'b1);
    drive(1'b0, 3'd0, '0, '0, 1'b1);
    chk("sat_true_cnt", 32'(true_cnt), 32'd15);

    // Random traffic with occasional mid-stream reset
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] m;
      case ($urandom_range(0, 3))
        0:       m = '0;
        1:       m = '1;
        2:       m = W'($urandom_range(0, 15));
        default: m = W'($urandom);
      endcase
      rst = ($urandom_range(0, 99) == 0);
      drive(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), W'($urandom), m,
            ($urandom_range(0, 2) != 0));
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) drive(1'b0, 3'd0, '0, '0, 1'b1);
    chk("drain_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
